// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mem_stage_pkg
// Description : Shared types and constants for the memory-stage SRAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] C_BASE_ADDR_DEFAULT = 32'd1024;
    localparam int          C_SRAM_AW           = 18;

endpackage : mem_stage_pkg
`default_nettype wire

// File: rtl/sram_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : sram_wait_counter
// Description : 3-bit wait-state counter; tc flags the last cycle of a phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sram_wait_counter #(
    parameter int WAIT_CYCLES = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tc
);

    logic [2:0] cnt_q;
    logic [2:0] cnt_d;

    // Clear wins over enable so a phase change restarts counting at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 3'd0;
        end else if (en) begin
            cnt_d = cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == 3'(WAIT_CYCLES - 1));

endmodule : sram_wait_counter
`default_nettype wire

// File: rtl/mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_sram_ctrl
// Description : 32-bit load/store over a 16-bit async SRAM in two wait-stated
//               half-word phases. Optional MEM_STAGE_ADDR_CHECK_EN rejects
//               out-of-range or misaligned addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int          WAIT_CYCLES = 5,
    parameter logic [31:0] BASE_ADDR   = C_BASE_ADDR_DEFAULT,
    parameter int          DEPTH_WORDS = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    input  logic [31:0]          alu_result,
    input  logic [31:0]          val_rm,
    output logic                 ready,
    output logic [31:0]          mem_result,
    output logic                 addr_err,
    output logic [C_SRAM_AW-1:0] sram_addr,
    output logic [15:0]          sram_wdata,
    input  logic [15:0]          sram_rdata,
    output logic                 sram_we_n,
    output logic                 sram_oe_n
);

    state_t               state_q, state_d;
    logic                 is_write_q, is_write_d;
    logic [C_SRAM_AW-2:0] idx_q, idx_d;
    logic [31:0]          wdata_q, wdata_d;
    logic [15:0]          lo_half_q, lo_half_d;
    logic [31:0]          mem_result_q, mem_result_d;
    logic                 addr_err_q, addr_err_d;

    logic        w_req;
    logic [31:0] w_offset;
    logic        w_tc;
    logic        w_cnt_en;
    logic        w_cnt_clr;
    logic        w_bad;
    logic        w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_offset = alu_result - BASE_ADDR;
    assign w_unused = ^{w_offset[31:19], w_offset[1:0], 1'(DEPTH_WORDS)};

`ifdef MEM_STAGE_ADDR_CHECK_EN
    localparam logic [32:0] C_LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    assign w_bad = (alu_result < BASE_ADDR) || ({1'b0, alu_result} >= C_LIMIT) ||
                   (alu_result[1:0] != 2'b00);
`else
    assign w_bad = 1'b0;
`endif

    sram_wait_counter #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_counter (
        .clk (clk),
        .rst (rst),
        .en  (w_cnt_en),
        .clr (w_cnt_clr),
        .tc  (w_tc)
    );

    always_comb begin
        state_d      = state_q;
        is_write_d   = is_write_q;
        idx_d        = idx_q;
        wdata_d      = wdata_q;
        lo_half_d    = lo_half_q;
        mem_result_d = mem_result_q;
        addr_err_d   = addr_err_q;
        w_cnt_en     = 1'b0;
        w_cnt_clr    = 1'b0;
        ready        = 1'b0;
        sram_addr    = '0;
        sram_wdata   = 16'h0000;
        sram_we_n    = 1'b1;
        sram_oe_n    = 1'b1;

        case (state_q)
            IDLE: begin
                ready     = ~w_req;
                w_cnt_clr = 1'b1;
                if (w_req) begin
                    is_write_d = mem_write;
                    idx_d      = w_offset[18:2];
                    wdata_d    = val_rm;
                    if (w_bad) begin
                        state_d    = DONE;
                        addr_err_d = 1'b1;
                        if (!mem_write) begin
                            mem_result_d = 32'h0;
                        end
                    end else begin
                        state_d = LO;
                    end
                end
            end
            LO, HI: begin
                w_cnt_en  = 1'b1;
                sram_addr = {idx_q, (state_q == HI)};
                if (is_write_q) begin
                    sram_wdata = (state_q == HI) ? wdata_q[31:16] : wdata_q[15:0];
                    // Release WE one cycle early so data is held past the strobe.
                    sram_we_n  = w_tc;
                end else begin
                    sram_oe_n  = 1'b0;
                end
                if (w_tc) begin
                    w_cnt_clr = 1'b1;
                    if (state_q == LO) begin
                        state_d = HI;
                        if (!is_write_q) begin
                            lo_half_d = sram_rdata;
                        end
                    end else begin
                        state_d = DONE;
                        if (!is_write_q) begin
                            mem_result_d = {sram_rdata, lo_half_q};
                        end
                    end
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            is_write_q   <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= 32'h0;
            lo_half_q    <= 16'h0000;
            mem_result_q <= 32'h0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_write_q   <= is_write_d;
            idx_q        <= idx_d;
            wdata_q      <= wdata_d;
            lo_half_q    <= lo_half_d;
            mem_result_q <= mem_result_d;
            addr_err_q   <= addr_err_d;
        end
    end

    assign mem_result = mem_result_q;
`ifdef MEM_STAGE_ADDR_CHECK_EN
    assign addr_err = addr_err_q;
`else
    assign addr_err = 1'b0;
`endif

endmodule : mem_stage_sram_ctrl
`default_nettype wire

// File: tb/tb_mem_stage_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_sram_ctrl
// Description : Directed self-checking bench for mem_stage_sram_ctrl (W=2).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_sram_ctrl;

    localparam int C_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] alu_result = 32'h0;
    logic [31:0] val_rm = 32'h0;
    logic        ready;
    logic [31:0] mem_result;
    logic        addr_err;
    logic [17:0] sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;
    logic        sram_we_n;
    logic        sram_oe_n;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mem    [0:63];
    int          we_cnt [0:63];
    int          oe_cnt = 0;

    mem_stage_sram_ctrl #(
        .WAIT_CYCLES (C_W),
        .BASE_ADDR   (32'd1024),
        .DEPTH_WORDS (65536)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .alu_result (alu_result),
        .val_rm     (val_rm),
        .ready      (ready),
        .mem_result (mem_result),
        .addr_err   (addr_err),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always #5 clk = ~clk;

    // SRAM model: a write lands on every clock the strobe is seen low.
    assign sram_rdata = mem[sram_addr[5:0]];
    always @(posedge clk) begin
        if (!sram_we_n) begin
            mem[sram_addr[5:0]] = sram_wdata;
            we_cnt[sram_addr[5:0]] = we_cnt[sram_addr[5:0]] + 1;
        end
        if (!sram_oe_n) oe_cnt = oe_cnt + 1;
    end

    task automatic clear_we_counts();
        for (int i = 0; i < 64; i++) we_cnt[i] = 0;
    endtask

    task automatic do_access(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                             output int stall, output logic [31:0] res, output bit timed_out);
        mem_write  = wr;
        mem_read   = !wr;
        alu_result = addr;
        val_rm     = data;
        stall      = 0;
        timed_out  = 1'b1;
        res        = 32'hxxxxxxxx;
        #1;
        if (!ready) stall = 1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (ready) begin
                res       = mem_result;
                timed_out = 1'b0;
                break;
            end
            stall++;
        end
    endtask

    task automatic go_idle();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b expected 1", ready); end
        vectors++;
        if ({sram_we_n, sram_oe_n} !== 2'b11) begin miscompares++; $display("FAIL reset_strobes: got %b expected 11", {sram_we_n, sram_oe_n}); end
        vectors++;
        if (mem_result !== 32'h0) begin miscompares++; $display("FAIL reset_mem_result: got %h expected 00000000", mem_result); end
        vectors++;
        if ({sram_addr, sram_wdata} !== 34'h0) begin miscompares++; $display("FAIL reset_pins: got addr %h wdata %h expected 0", sram_addr, sram_wdata); end
        vectors++;
        if (addr_err !== 1'b0) begin miscompares++; $display("FAIL reset_addr_err: got %b expected 0", addr_err); end
    endtask

    task automatic test_store();
        int          stall;
        logic [31:0] res;
        bit          to;
        int          oe_before;
        clear_we_counts();
        oe_before = oe_cnt;
        do_access(1'b1, 32'd1024, 32'hDEADBEEF, stall, res, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL store_timeout: got timeout expected done"); end
        vectors++;
        if (stall !== 5) begin miscompares++; $display("FAIL store_stall: got %0d expected 5", stall); end
        vectors++;
        if (mem[0] !== 16'hBEEF) begin miscompares++; $display("FAIL store_hw0: got %h expected beef", mem[0]); end
        vectors++;
        if (mem[1] !== 16'hDEAD) begin miscompares++; $display("FAIL store_hw1: got %h expected dead", mem[1]); end
        vectors++;
        if (we_cnt[0] !== 1 || we_cnt[1] !== 1) begin miscompares++; $display("FAIL store_we_len: got %0d/%0d expected 1/1", we_cnt[0], we_cnt[1]); end
        vectors++;
        if (oe_cnt !== oe_before) begin miscompares++; $display("FAIL store_no_oe: got %0d expected %0d", oe_cnt, oe_before); end
        go_idle();
        vectors++;
        if ({ready, sram_we_n, sram_oe_n} !== 3'b111) begin miscompares++; $display("FAIL store_after_idle: got %b expected 111", {ready, sram_we_n, sram_oe_n}); end
    endtask

    task automatic test_load();
        int          stall;
        logic [31:0] res;
        bit          to;
        int          oe_before;
        oe_before = oe_cnt;
        clear_we_counts();
        do_access(1'b0, 32'd1028, 32'h0, stall, res, to);
        vectors++;
        if (to) begin miscompares++; $display("FAIL load_timeout: got timeout expected done"); end
        vectors++;
        if (stall !== 5) begin miscompares++; $display("FAIL load_stall: got %0d expected 5", stall); end
        vectors++;
        if (res !== 32'h56781234) begin miscompares++; $display("FAIL load_result: got %h expected 56781234", res); end
        vectors++;
        if (oe_cnt - oe_before !== 2 * C_W) begin miscompares++; $display("FAIL load_oe_len: got %0d expected 4", oe_cnt - oe_before); end
        vectors++;
        if (we_cnt[2] !== 0 || we_cnt[3] !== 0) begin miscompares++; $display("FAIL load_no_we: got %0d/%0d expected 0/0", we_cnt[2], we_cnt[3]); end
        go_idle();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (mem_result !== 32'h56781234) begin miscompares++; $display("FAIL load_held: got %h expected 56781234", mem_result); end
    endtask

    task automatic test_back_to_back();
        int          stall;
        logic [31:0] res;
        bit          to;
        do_access(1'b1, 32'd1032, 32'hCAFEF00D, stall, res, to);
        vectors++;
        if (to || stall !== 5) begin miscompares++; $display("FAIL b2b_store_stall: got %0d (timeout %b) expected 5", stall, to); end
        // Request switches to the load while the store is in its DONE cycle.
        do_access(1'b0, 32'd1032, 32'h0, stall, res, to);
        vectors++;
        if (to || stall !== 5) begin miscompares++; $display("FAIL b2b_load_stall: got %0d (timeout %b) expected 5", stall, to); end
        vectors++;
        if (res !== 32'hCAFEF00D) begin miscompares++; $display("FAIL b2b_load_result: got %h expected cafef00d", res); end
        go_idle();
    endtask

    task automatic test_reset_mid_write();
        int          stall;
        logic [31:0] res;
        bit          to;
        mem_write  = 1'b1;
        alu_result = 32'd1040;
        val_rm     = 32'h11112222;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({sram_addr, sram_we_n, sram_wdata} !== {18'd9, 1'b0, 16'h1111}) begin
            miscompares++;
            $display("FAIL mid_hi_pins: got addr %0d we_n %b wdata %h expected 9 0 1111", sram_addr, sram_we_n, sram_wdata);
        end
        rst       = 1'b1;
        mem_write = 1'b0;
        #1;
        vectors++;
        if ({sram_we_n, sram_oe_n} !== 2'b11) begin miscompares++; $display("FAIL mid_rst_strobes: got %b expected 11", {sram_we_n, sram_oe_n}); end
        vectors++;
        if (sram_addr !== 18'd0) begin miscompares++; $display("FAIL mid_rst_addr: got %h expected 0", sram_addr); end
        vectors++;
        if (mem_result !== 32'h0) begin miscompares++; $display("FAIL mid_rst_mem_result: got %h expected 00000000", mem_result); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_ready: got %b expected 1", ready); end
        do_access(1'b0, 32'd1028, 32'h0, stall, res, to);
        vectors++;
        if (to || stall !== 5 || res !== 32'h56781234) begin
            miscompares++;
            $display("FAIL post_rst_load: got stall %0d res %h expected 5 56781234", stall, res);
        end
        go_idle();
    endtask

`ifdef MEM_STAGE_ADDR_CHECK_EN
    task automatic test_addr_check();
        int          stall;
        logic [31:0] res;
        bit          to;
        int          oe_before;
        oe_before = oe_cnt;
        clear_we_counts();
        do_access(1'b0, 32'd1022, 32'h0, stall, res, to);
        vectors++;
        if (to || stall !== 1) begin miscompares++; $display("FAIL chk_low_stall: got %0d expected 1", stall); end
        vectors++;
        if (res !== 32'h0) begin miscompares++; $display("FAIL chk_low_result: got %h expected 00000000", res); end
        vectors++;
        if (addr_err !== 1'b1) begin miscompares++; $display("FAIL chk_addr_err_set: got %b expected 1", addr_err); end
        vectors++;
        if (oe_cnt !== oe_before) begin miscompares++; $display("FAIL chk_no_oe: got %0d expected %0d", oe_cnt, oe_before); end
        go_idle();
        do_access(1'b1, 32'd1030, 32'hFFFFFFFF, stall, res, to);
        vectors++;
        if (to || stall !== 1) begin miscompares++; $display("FAIL chk_misalign_stall: got %0d expected 1", stall); end
        go_idle();
        do_access(1'b1, 32'd263168, 32'hFFFFFFFF, stall, res, to);
        vectors++;
        if (to || stall !== 1) begin miscompares++; $display("FAIL chk_high_stall: got %0d expected 1", stall); end
        vectors++;
        if (we_cnt[0] + we_cnt[1] + we_cnt[2] + we_cnt[3] !== 0) begin miscompares++; $display("FAIL chk_no_we: got writes expected none"); end
        go_idle();
        do_access(1'b0, 32'd1028, 32'h0, stall, res, to);
        vectors++;
        if (to || stall !== 5 || res !== 32'h56781234) begin miscompares++; $display("FAIL chk_valid_load: got stall %0d res %h expected 5 56781234", stall, res); end
        vectors++;
        if (addr_err !== 1'b1) begin miscompares++; $display("FAIL chk_addr_err_sticky: got %b expected 1", addr_err); end
        go_idle();
        rst = 1'b1;
        #1;
        vectors++;
        if (addr_err !== 1'b0) begin miscompares++; $display("FAIL chk_addr_err_rst: got %b expected 0", addr_err); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask
`else
    task automatic test_addr_check();
        vectors++;
        if (addr_err !== 1'b0) begin miscompares++; $display("FAIL addr_err_tied: got %b expected 0", addr_err); end
    endtask
`endif

    initial begin
        for (int i = 0; i < 64; i++) begin
            mem[i]    = 16'h0000;
            we_cnt[i] = 0;
        end
        mem[2] = 16'h1234;
        mem[3] = 16'h5678;
        test_reset();
        test_store();
        test_load();
        test_back_to_back();
        test_reset_mid_write();
        test_addr_check();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_mem_stage_sram_ctrl
`default_nettype wire
